// File: rtl/demux_word_collector.sv
// Collects demux-routed bits LSB-first into 8 per-channel words, emitted tagged with channel.
// Latency: 1 clk from final accepted bit to out_valid. Optional ROUTE_CHECK_EN builds sticky route_err.
// Backpressure: single output slot; in_ready drops for all channels while slot is full and not draining.
module demux_word_collector #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        sel,
    input  logic [7:0]        Y_in,
    input  logic [7:0]        clr_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] word_out,
    output logic [2:0]        word_ch,
    output logic              route_err
);

    localparam int CNT_W = $clog2(WORD_W);

    logic [WORD_W-1:0] shreg [8];
    logic [CNT_W-1:0]  cnt   [8];

    logic              acc;
    logic              b;
    logic              last_bit;
    logic              complete;
    logic [WORD_W-1:0] next_word;

    assign in_ready  = !out_valid || out_ready;
    assign acc       = in_valid && in_ready;
    assign b         = Y_in[sel];
    assign next_word = {b, shreg[sel][WORD_W-1:1]};
    assign last_bit  = (cnt[sel] == CNT_W'(WORD_W - 1));
    // A clear on the same channel drops the completing bit, so no word is produced.
    assign complete  = acc && last_bit && !clr_ch[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                shreg[i] <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (clr_ch[i] || (complete && sel == 3'(i))) begin
                    shreg[i] <= '0;
                    cnt[i]   <= '0;
                end else if (acc && sel == 3'(i)) begin
                    shreg[i] <= next_word;
                    cnt[i]   <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A completing beat can only be accepted when the slot is empty or draining, so it loads directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            word_out  <= '0;
            word_ch   <= '0;
        end else if (complete) begin
            out_valid <= 1'b1;
            word_out  <= next_word;
            word_ch   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ROUTE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            route_err <= 1'b0;
        end else if (acc && ((Y_in & ~(8'b1 << sel)) != 8'h00)) begin
            route_err <= 1'b1;
        end
    end
`else
    assign route_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_word_collector.sv
// Directed bench for demux_word_collector: inputs driven and outputs sampled on the falling edge.
module tb_demux_word_collector;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic [7:0] Y_in;
    logic [7:0] clr_ch;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] word_out;
    logic [2:0] word_ch;
    logic       route_err;

    int checks = 0;
    int errors = 0;

`ifdef ROUTE_CHECK_EN
    localparam logic EXP_RERR = 1'b1;
`else
    localparam logic EXP_RERR = 1'b0;
`endif

    demux_word_collector #(.WORD_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .Y_in      (Y_in),
        .clr_ch    (clr_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_out  (word_out),
        .word_ch   (word_ch),
        .route_err (route_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents one routed bit and advances through one rising edge.
    task automatic beat(input logic [2:0] ch, input logic bv);
        in_valid = 1'b1;
        sel      = ch;
        Y_in     = 8'(bv) << ch;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        Y_in     = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; sel = 3'd0; Y_in = 8'h00;
        clr_ch = 8'h00; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || word_out !== 8'h00 || word_ch !== 3'd0 || route_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b w=%h ch=%0d re=%b want 0 00 0 0",
                     out_valid, word_out, word_ch, route_err);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [7:0] bits;
        bits = 8'b0100_1101;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beat(3'd3, bits[i]);
            if (i < 7) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL single_early_valid: beat %0d got %b want 0", i, out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || word_out !== 8'h4D || word_ch !== 3'd3) begin
            errors++;
            $display("FAIL single_word: got v=%b w=%h ch=%0d want 1 4d 3", out_valid, word_out, word_ch);
        end
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_interleave();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            sel      = (i % 2 == 0) ? 3'd0 : 3'd7;
            Y_in     = (i % 2 == 0) ? 8'h01 : 8'h00;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL interleave_ready: beat %0d got %b want 1", i, in_ready);
            end
            @(negedge clk);
            if (i == 14) begin
                checks++;
                if (out_valid !== 1'b1 || word_out !== 8'hFF || word_ch !== 3'd0) begin
                    errors++;
                    $display("FAIL interleave_ch0: got v=%b w=%h ch=%0d want 1 ff 0",
                             out_valid, word_out, word_ch);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || word_out !== 8'h00 || word_ch !== 3'd7) begin
            errors++;
            $display("FAIL interleave_ch7: got v=%b w=%h ch=%0d want 1 00 7", out_valid, word_out, word_ch);
        end
        idle();
    endtask

    task automatic test_backpressure();
        logic [7:0] b4;
        b4 = 8'hAA;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) beat(3'd4, b4[i]);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(3'd1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || word_out !== 8'hFF || word_ch !== 3'd1) begin
            errors++;
            $display("FAIL bp_first: got v=%b w=%h ch=%0d want 1 ff 1", out_valid, word_out, word_ch);
        end
        in_valid = 1'b1; sel = 3'd4; Y_in = 8'h10;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || word_out !== 8'hFF || word_ch !== 3'd1) begin
            errors++;
            $display("FAIL bp_hold: got v=%b w=%h ch=%0d want 1 ff 1", out_valid, word_out, word_ch);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || word_out !== 8'hAA || word_ch !== 3'd4) begin
            errors++;
            $display("FAIL bp_second: got v=%b w=%h ch=%0d want 1 aa 4", out_valid, word_out, word_ch);
        end
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] bits;
        bits = 8'hF0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) beat(3'd2, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(3'd6, 1'b1);
        in_valid = 1'b0; Y_in = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || word_out !== 8'h00 || word_ch !== 3'd0 || route_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b w=%h ch=%0d re=%b want 0 00 0 0",
                     out_valid, word_out, word_ch, route_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            beat(3'd2, bits[i]);
            if (i < 7) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_leftover: beat %0d got v=%b want 0", i, out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || word_out !== 8'hF0 || word_ch !== 3'd2) begin
            errors++;
            $display("FAIL reset_fresh_word: got v=%b w=%h ch=%0d want 1 f0 2", out_valid, word_out, word_ch);
        end
        idle();
    endtask

    task automatic test_clear();
        logic [7:0] bits;
        bits = 8'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) beat(3'd5, 1'b1);
        clr_ch = 8'h20;
        beat(3'd5, 1'b1);
        clr_ch = 8'h00;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_word: got v=%b want 0", out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            beat(3'd5, bits[i]);
            if (i < 7) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_leftover: beat %0d got v=%b want 0", i, out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || word_out !== 8'h33 || word_ch !== 3'd5) begin
            errors++;
            $display("FAIL clr_next_word: got v=%b w=%h ch=%0d want 1 33 5", out_valid, word_out, word_ch);
        end
        idle();
    endtask

    task automatic test_route_check();
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 3'd1; Y_in = 8'b0000_0110;
        @(negedge clk);
        checks++;
        if (route_err !== EXP_RERR) begin
            errors++;
            $display("FAIL route_err_set: got %b want %b", route_err, EXP_RERR);
        end
        for (int i = 0; i < 7; i++) beat(3'd1, 1'b0);
        in_valid = 1'b0; Y_in = 8'h00;
        checks++;
        if (out_valid !== 1'b1 || word_out !== 8'h01 || word_ch !== 3'd1) begin
            errors++;
            $display("FAIL route_data: got v=%b w=%h ch=%0d want 1 01 1", out_valid, word_out, word_ch);
        end
        checks++;
        if (route_err !== EXP_RERR) begin
            errors++;
            $display("FAIL route_err_sticky: got %b want %b", route_err, EXP_RERR);
        end
        clr_ch = 8'h02;
        @(negedge clk);
        clr_ch = 8'h00;
        checks++;
        if (out_valid !== 1'b1 || word_out !== 8'h01 || word_ch !== 3'd1) begin
            errors++;
            $display("FAIL clr_slot_untouched: got v=%b w=%h ch=%0d want 1 01 1", out_valid, word_out, word_ch);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL route_drain: got %b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_interleave();
        test_backpressure();
        test_async_reset();
        test_clear();
        test_route_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
